// File: rtl/regfile_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_alu_issue_ctrl
//   Issue controller in front of simple_regfile_alu. Two requesters share the
//   single regfile/ALU datapath through a round-robin arbiter with a
//   valid/ready handshake. Sources that match the rd of a recently issued op
//   are stalled until its writeback is visible. Idle cycles issue a bubble
//   (r0 <= r0 + 0). Writeback completion is reported WB_LAT edges after
//   issue, and halt drains all in-flight ops before stopping.
//
// Ports
//   clk, rst                      clock / async active-high reset
//   reqN_valid, reqN_ready        requester N handshake (ready is combinational)
//   reqN_rs1/rs2/rd               requester N register addresses
//   reqN_immflag, reqN_imm        requester N immediate select / value
//   halt, halted                  drain request / stopped indication
//   alu_rs1/rs2/rd/immflag/imm    registered op towards the datapath
//   alu_issue                     alu_* holds a real op (not a bubble)
//   done_valid, done_id, done_rd  one-cycle writeback-complete pulse
//
// WB_LAT must lie in 1..4.
// ---------------------------------------------------------------------------

// Per-requester hazard check against the recent-issue history.
module regfile_alu_issue_hzd #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1
) (
    input  logic [ADDR_WIDTH-1:0]            rs1_i,
    input  logic [ADDR_WIDTH-1:0]            rs2_i,
    input  logic                             immflag_i,
    input  logic [DEPTH-1:0]                 hv_i,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] hrd_i,
    output logic                             blocked_o
);
    // A zero rd never hazards; rs2 only counts when the immediate is unused.
    always_comb begin
        blocked_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hv_i[i] && (hrd_i[i] != '0)) begin
                if (hrd_i[i] == rs1_i)
                    blocked_o = 1'b1;
                if (!immflag_i && (hrd_i[i] == rs2_i))
                    blocked_o = 1'b1;
            end
        end
    end
endmodule

module regfile_alu_issue_ctrl #(
    parameter int REG_WIDTH  = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int WB_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_rs1,
    input  logic [ADDR_WIDTH-1:0] req0_rs2,
    input  logic [ADDR_WIDTH-1:0] req0_rd,
    input  logic                  req0_immflag,
    input  logic [REG_WIDTH-1:0]  req0_imm,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_rs1,
    input  logic [ADDR_WIDTH-1:0] req1_rs2,
    input  logic [ADDR_WIDTH-1:0] req1_rd,
    input  logic                  req1_immflag,
    input  logic [REG_WIDTH-1:0]  req1_imm,

    input  logic                  halt,
    output logic                  halted,

    output logic [ADDR_WIDTH-1:0] alu_rs1,
    output logic [ADDR_WIDTH-1:0] alu_rs2,
    output logic [ADDR_WIDTH-1:0] alu_rd,
    output logic                  alu_immflag,
    output logic [REG_WIDTH-1:0]  alu_imm,
    output logic                  alu_issue,

    output logic                  done_valid,
    output logic                  done_id,
    output logic [ADDR_WIDTH-1:0] done_rd
);
    localparam int NUM_REQ = 2;
    // Hazard window covers the ops issued at the last WB_LAT-1 edges. With
    // WB_LAT=1 the window is empty; keep one masked-off entry so the checker
    // still has a legal width.
    localparam int HD  = (WB_LAT > 1) ? WB_LAT - 1 : 1;
    localparam bit HEN = (WB_LAT > 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    // Requester fields packed by index for the per-requester logic.
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_immflag;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_rs1;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_rs2;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_rd;
    logic [NUM_REQ-1:0][REG_WIDTH-1:0]  req_imm;

    logic [NUM_REQ-1:0] blocked;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic               gsel;

    state_t state_q;
    logic   halted_q;
    logic   ptr_q;      // 0: req0 preferred, 1: req1 preferred

    // Issue/completion pipeline. Stage 0 is the op currently on alu_*, stage
    // i was issued i edges ago, stage WB_LAT drives the done pulse.
    logic [WB_LAT:0]                 pv_q, pv_d;
    logic [WB_LAT:0]                 pid_q, pid_d;
    logic [WB_LAT:0][ADDR_WIDTH-1:0] prd_q, prd_d;

    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic                  immf_q, immf_d;
    logic [REG_WIDTH-1:0]  imm_q, imm_d;

    logic [HD-1:0]                 hv;
    logic [HD-1:0][ADDR_WIDTH-1:0] hrd;
    logic                          pipe_empty;

    assign req_valid   = {req1_valid,   req0_valid};
    assign req_immflag = {req1_immflag, req0_immflag};
    assign req_rs1     = {req1_rs1,     req0_rs1};
    assign req_rs2     = {req1_rs2,     req0_rs2};
    assign req_rd      = {req1_rd,      req0_rd};
    assign req_imm     = {req1_imm,     req0_imm};

    assign hv  = pv_q[HD-1:0] & {HD{HEN}};
    assign hrd = prd_q[HD-1:0];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        regfile_alu_issue_hzd #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (HD)
        ) u_hzd (
            .rs1_i     (req_rs1[g]),
            .rs2_i     (req_rs2[g]),
            .immflag_i (req_immflag[g]),
            .hv_i      (hv),
            .hrd_i     (hrd),
            .blocked_o (blocked[g])
        );
    end

    assign elig = req_valid & ~blocked & {NUM_REQ{state_q == ST_RUN}};

    // A blocked preferred requester does not hold off an eligible one.
    assign grant[0] = elig[0] & (~elig[1] | ~ptr_q);
    assign grant[1] = elig[1] & (~elig[0] |  ptr_q);
    assign xfer     = |grant;
    assign gsel     = grant[1];

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Drain may finish once nothing is left that could still write back; the
    // done stage itself is allowed to pulse on the same edge.
    assign pipe_empty = ~|pv_q[WB_LAT-1:0];

    always_comb begin
        pv_d     = '0;
        pid_d    = '0;
        prd_d    = '0;
        pv_d[0]  = xfer;
        pid_d[0] = xfer & gsel;
        prd_d[0] = xfer ? req_rd[gsel] : '0;
        for (int i = 1; i <= WB_LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
            prd_d[i] = prd_q[i-1];
        end
        // No transfer loads the bubble: r0 <= r0 + 0.
        rs1_d  = xfer ? req_rs1[gsel]     : '0;
        rs2_d  = xfer ? req_rs2[gsel]     : '0;
        immf_d = xfer ? req_immflag[gsel] : 1'b1;
        imm_d  = xfer ? req_imm[gsel]     : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q   <= '0;
            pid_q  <= '0;
            prd_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            immf_q <= 1'b1;
            imm_q  <= '0;
            ptr_q  <= 1'b0;
        end else begin
            pv_q   <= pv_d;
            pid_q  <= pid_d;
            prd_q  <= prd_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            immf_q <= immf_d;
            imm_q  <= imm_d;
            if (xfer)
                ptr_q <= ~gsel;
        end
    end

    // Run / drain / halted control. The grant made in the cycle halt is
    // sampled still issues, since grants depend on the pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt)
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign halted      = halted_q;
    assign alu_rs1     = rs1_q;
    assign alu_rs2     = rs2_q;
    assign alu_rd      = prd_q[0];
    assign alu_immflag = immf_q;
    assign alu_imm     = imm_q;
    assign alu_issue   = pv_q[0];
    assign done_valid  = pv_q[WB_LAT];
    assign done_id     = pid_q[WB_LAT];
    assign done_rd     = prd_q[WB_LAT];

endmodule

// File: doc/regfile_alu_issue_ctrl.md
Name: regfile_alu_issue_ctrl

Overview:
Issue controller and arbiter sitting in front of simple_regfile_alu. It shares the single regfile/ALU datapath between two requesters using round-robin arbitration and a valid/ready handshake. It stalls read-after-write hazards against in-flight writes, inserts bubble ops when idle, reports writeback completion, and supports a halt/drain sequence.

Parameters:
REG_WIDTH, 64, datapath/immediate width
ADDR_WIDTH, 5, register address width
WB_LAT, 1, edges from issue to visible writeback (legal 1..4)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 op valid
req0_ready  out  1  requester 0 op accepted this cycle
req0_rs1/req0_rs2/req0_rd  in  ADDR_WIDTH each  requester 0 source/dest
req0_immflag  in  1  requester 0 uses immediate in place of rs2
req0_imm  in  REG_WIDTH  requester 0 immediate
req1_*  same set as req0_*, for requester 1
halt  in  1  request drain and stop
halted  out  1  controller idle and stopped
alu_rs1/alu_rs2/alu_rd  out  ADDR_WIDTH each  to datapath inst_rs1/inst_rs2/inst_rd
alu_immflag  out  1  to datapath inst_immflag
alu_imm  out  REG_WIDTH  to datapath imm_data
alu_issue  out  1  alu_* holds a real op (not a bubble)
done_valid  out  1  one-cycle writeback-complete pulse
done_id  out  1  requester of completed op
done_rd  out  ADDR_WIDTH  dest of completed op

Behaviour:
- Datapath writes alu_rd every posedge. alu_* outputs are registered, so they always hold a valid op.
- Bubble op: rs1=0, rs2=0, rd=0, immflag=1, imm=0, alu_issue=0. It writes 0 to r0, which keeps r0 at zero.
- Reset values:
  - alu_* = bubble, alu_issue=0.
  - done_valid=0, done_id=0, done_rd=0, halted=0.
  - FSM=RUN, round-robin pointer prefers req0, scoreboard empty.
- Reset mid-operation discards all in-flight ops; no done pulses are produced for them.
- Sources in use:
  - rs1 always.
  - rs2 only when immflag=0.
  - Address 0 never hazards.
- Hazard: a candidate is blocked if any op issued at the previous WB_LAT-1 edges has rd equal to a source in use and that rd is nonzero. With WB_LAT=1, no stalls ever occur.
- Eligible = valid and not blocked and FSM==RUN.
- Arbitration:
  - If both requesters are eligible, grant the preferred one.
  - If only one is eligible, grant it, even if the preferred one is valid but blocked.
  - After a grant, the pointer prefers the other requester.
  - The pointer is unchanged when nothing is granted.
- reqN_ready = grantN, combinational. It may depend on reqN_valid. At most one ready per cycle.
- Transfer occurs on a posedge with valid and ready both high. At that edge, alu_* loads the granted op and alu_issue=1. With no transfer, alu_* loads the bubble.
- Issue latency: an op presented at cycle C appears on alu_* after the posedge ending C.
- Completion: an op issued at edge T raises done_valid for the one cycle following edge T+WB_LAT, with done_id and done_rd of that op. Back-to-back issues give back-to-back done pulses.
- Requesters must hold their fields stable while valid=1 and ready=0.
- FSM:
  - RUN: grants allowed. halt=1 sampled at a posedge moves to DRAIN; the grant in that same cycle still completes.
  - DRAIN: no grants, bubbles issued. Moves to HALTED at the edge when the scoreboard and completion pipeline are empty. halt deasserting during DRAIN does not abort the drain.
  - HALTED: halted=1, no grants. halt=0 sampled moves to RUN.
- No op is ever lost or duplicated across halt or arbitration.

Test Plan:
- Reset then idle 4 cycles -> alu_issue=0, alu_rd=0, regfile[0]=0, halted=0, no done pulses.
- req0: rd=1, immflag=1, imm=10, then req1: rd=2, immflag=1, imm=20, then req0: rs1=1, rs2=2, rd=3, immflag=0 -> regfile[1]=10, regfile[2]=20, regfile[3]=30. done pulses in order (id0,rd1), (id1,rd2), (id0,rd3).
- Both requesters valid continuously for 6 ops each -> grants alternate 0,1,0,1…, with req0 first after reset.
- WB_LAT=3:
  - req0 writes rd=3 (imm 30), req0 then issues rs1=3, rd=4, imm=5. The second op stalls 2 cycles and regfile[4]=35.
  - Meanwhile, an unrelated req1 op (rs1=0, rd=5, imm=7) is granted during the stall.
- halt asserted while ops are in flight -> no new ready, done pulses for in-flight ops, halted=1 after drain. Deassert halt -> the held valid req is granted next cycle.
- rst pulsed mid-stream with WB_LAT=3 -> outputs return to bubble immediately, no done pulses for discarded ops, pointer prefers req0.
